// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch PC sequencer; HLT detection guarded by HALT_DETECT_EN
module pc_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    output logic [15:0] inc_PC_out,
    output logic [15:0] instr_out,
    output logic        flush_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        deliver;
    logic        is_hlt;

    always_comb begin
        deliver = !rst && (state_q != S_HALT) && imem_ready && !branch_taken;
`ifdef HALT_DETECT_EN
        is_hlt  = (imem_rdata[15:12] == 4'hF);
`else
        is_hlt  = 1'b0;
`endif
        state_d = state_q;
        pc_d    = pc_q;
        // A redirect wins over everything, including a pending fetch or HALT.
        if (branch_taken) begin
            pc_d    = {branch_target[15:1], 1'b0};
            state_d = S_FETCH;
        end else if (state_q != S_HALT && !stall) begin
            if (imem_ready) begin
                if (is_hlt) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + 16'd2;
                    state_d = S_FETCH;
                end
            end else begin
                state_d = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inc_PC_out = pc_q + 16'd2;
    assign imem_req   = (state_q != S_HALT);
    assign instr_out  = deliver ? imem_rdata : 16'h0000;
    assign flush_out  = branch_taken && !rst;

`ifdef HALT_DETECT_EN
    logic halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == S_HALT);
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit against a behavioural fetch model
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] inc_PC_out;
    logic [15:0] instr_out;
    logic        flush_out;
    logic        halted;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .inc_PC_out   (inc_PC_out),
        .instr_out    (instr_out),
        .flush_out    (flush_out),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] inc;
        logic [15:0] instr;
        logic        flush;
        logic        req;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    // Reference model: architectural PC and halted flag only.
    int   m_pc     = 0;
    bit   m_halted = 0;
`ifdef HALT_DETECT_EN
    localparam bit HLT_EN = 1;
`else
    localparam bit HLT_EN = 0;
`endif

    task automatic cyc(input logic r, input logic s, input logic b,
                       input logic [15:0] t, input logic [15:0] d, input logic rd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; branch_taken = b; branch_target = t;
        imem_rdata = d; imem_ready = rd;
        if (r) begin
            m_pc = 0;
            m_halted = 0;
        end
        e.addr  = 16'(m_pc);
        e.inc   = 16'((m_pc + 2) % 65536);
        e.req   = !m_halted;
        e.hlt   = m_halted;
        e.flush = b && !r;
        e.instr = (!r && !m_halted && rd && !b) ? d : 16'h0000;
        exp_q.push_back(e);
        if (r) begin
            m_pc = 0;
        end else if (b) begin
            m_pc = (int'(t) / 2) * 2;
            m_halted = 0;
        end else if (!m_halted && !s && rd) begin
            if (HLT_EN && d[15:12] == 4'hF) m_halted = 1;
            else m_pc = (m_pc + 2) % 65536;
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n_cycle, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk16("imem_addr", imem_addr, e.addr);
                chk16("inc_PC_out", inc_PC_out, e.inc);
                chk16("instr_out", instr_out, e.instr);
                chk16("flush_out", {15'd0, flush_out}, {15'd0, e.flush});
                chk16("imem_req", {15'd0, imem_req}, {15'd0, e.req});
                chk16("halted", {15'd0, halted}, {15'd0, e.hlt});
                n_cycle++;
            end
        end
    end

    initial begin : stim
        logic [15:0] d;
        // reset state, then sequential fetch
        cyc(1, 0, 0, 16'h0, 16'h1234, 1);
        cyc(1, 0, 0, 16'h0, 16'h1234, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0, 16'h1000 + 16'(i), 1);
        // three-cycle memory wait at 0x0010
        cyc(0, 0, 1, 16'h0010, 16'h0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0, 16'hBEEF, 0);
        cyc(0, 0, 0, 16'h0, 16'h2222, 1);
        cyc(0, 0, 0, 16'h0, 16'h3333, 1);
        // stall held, then stall together with branch to odd target
        cyc(0, 1, 0, 16'h0, 16'h4444, 1);
        cyc(0, 1, 1, 16'h0041, 16'h5555, 1);
        cyc(0, 0, 0, 16'h0, 16'h6666, 1);
        // wrap at top of address space
        cyc(0, 0, 1, 16'hFFFF, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 16'h7777, 1);
        cyc(0, 0, 0, 16'h0, 16'h8888, 1);
        // HLT word at 0x0020, sit in it, then branch away
        cyc(0, 0, 1, 16'h0020, 16'h0, 0);
        cyc(0, 0, 0, 16'h0, 16'hF000, 1);
        cyc(0, 0, 0, 16'h0, 16'h9999, 1);
        cyc(0, 0, 0, 16'h0, 16'hAAAA, 1);
        cyc(0, 0, 1, 16'h0030, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 16'hBBBB, 1);
        // reset during WAIT at 0x0100, then late ready
        cyc(0, 0, 1, 16'h0100, 16'h0, 0);
        cyc(0, 0, 0, 16'h0, 16'h0, 0);
        cyc(1, 0, 0, 16'h0, 16'hCCCC, 1);
        cyc(0, 0, 0, 16'h0, 16'hDDDD, 1);
        cyc(0, 0, 0, 16'h0, 16'hEEEE, 1);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            d = 16'($urandom);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), 16'($urandom), d,
                ($urandom_range(0, 3) != 0));
        end
        cyc(0, 0, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
